// File: rtl/lsu_data_memory_pkg.sv
// lsu_data_memory_pkg: shared access-size, state encodings and counter sizing for the LSU data memory.
package lsu_mem_pkg;
  localparam logic ACC_WORD = 1'b0;
  localparam logic ACC_BYTE = 1'b1;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
  function automatic int cnt_width(input int latency);
    return latency > 1 ? $clog2(latency) : 1;
  endfunction
endpackage

// File: rtl/lsu_data_memory_channel.sv
// mem_latency_channel: captures a request, counts LATENCY cycles, and flags the completing edge.
module mem_latency_channel
  import lsu_mem_pkg::*;
#(
  parameter int LATENCY = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_enable,
  input  logic [31:0]   i_address,
  input  logic [DW-1:0] i_data,
  output logic          o_done,
  output logic [31:0]   o_address,
  output logic [DW-1:0] o_data
);
  localparam int CW = cnt_width(LATENCY);
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      o_address <= '0;
      o_data    <= '0;
    end else if (r_state == ST_IDLE) begin
      if (i_enable) begin
        r_state   <= ST_BUSY;
        r_cnt     <= CW'(LATENCY - 1);
        o_address <= i_address;
        o_data    <= i_data;
      end
    end else begin
      r_cnt   <= r_cnt - 1'b1;
      r_state <= r_cnt == '0 ? ST_IDLE : ST_BUSY;
    end
  end
  // The access happens on the edge that ends the last BUSY cycle.
  assign o_done = r_state == ST_BUSY && r_cnt == '0;
endmodule

// File: rtl/lsu_data_memory.sv
// lsu_data_memory: byte-addressable little-endian memory with independent fixed-latency read/write channels.
module lsu_data_memory
  import lsu_mem_pkg::*;
#(
  parameter int MEM_SIZE_BYTES = 8192,
  parameter int WRITE_LATENCY = 10,
  parameter int READ_LATENCY = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        write_enable,
  input  logic [31:0] write_address,
  input  logic [31:0] write_value,
  input  logic        store_byte,
  input  logic        read_enable,
  input  logic [31:0] read_address,
  input  logic        load_byte,
  output logic [31:0] read_value,
  output logic        write_valid,
  output logic        read_valid,
  output logic        read_error,
  output logic        write_error
);
  localparam int AW = $clog2(MEM_SIZE_BYTES);
  logic [7:0]  r_mem [MEM_SIZE_BYTES] = '{default: 8'h00};
  logic        w_wr_done, w_rd_done, w_rd_size, w_wr_oob, w_rd_oob;
  logic [31:0] w_wr_addr, w_rd_addr, w_wr_base, w_rd_base;
  logic [32:0] w_wr_data;
  logic [AW-1:0] w_wr_idx, w_rd_idx;
  mem_latency_channel #(.LATENCY(WRITE_LATENCY), .DW(33)) u_wr (
    .clk(clk), .reset_n(reset_n), .i_enable(write_enable), .i_address(write_address),
    .i_data({store_byte, write_value}), .o_done(w_wr_done), .o_address(w_wr_addr), .o_data(w_wr_data)
  );
  mem_latency_channel #(.LATENCY(READ_LATENCY), .DW(1)) u_rd (
    .clk(clk), .reset_n(reset_n), .i_enable(read_enable), .i_address(read_address),
    .i_data(load_byte), .o_done(w_rd_done), .o_address(w_rd_addr), .o_data(w_rd_size)
  );
  // Word accesses use the aligned base for both indexing and the range check.
  assign w_wr_base = w_wr_data[32] == ACC_BYTE ? w_wr_addr : {w_wr_addr[31:2], 2'b00};
  assign w_rd_base = w_rd_size == ACC_BYTE ? w_rd_addr : {w_rd_addr[31:2], 2'b00};
  assign w_wr_oob  = w_wr_base >= 32'(MEM_SIZE_BYTES);
  assign w_rd_oob  = w_rd_base >= 32'(MEM_SIZE_BYTES);
  assign w_wr_idx  = w_wr_base[AW-1:0];
  assign w_rd_idx  = w_rd_base[AW-1:0];
  always_ff @(posedge clk) begin
    if (w_wr_done && !w_wr_oob) begin
      r_mem[w_wr_idx] <= w_wr_data[7:0];
      if (w_wr_data[32] == ACC_WORD) begin
        r_mem[{w_wr_idx[AW-1:2], 2'd1}] <= w_wr_data[15:8];
        r_mem[{w_wr_idx[AW-1:2], 2'd2}] <= w_wr_data[23:16];
        r_mem[{w_wr_idx[AW-1:2], 2'd3}] <= w_wr_data[31:24];
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_value  <= '0;
      read_valid  <= 1'b0;
      read_error  <= 1'b0;
      write_valid <= 1'b0;
      write_error <= 1'b0;
    end else begin
      write_valid <= w_wr_done;
      write_error <= w_wr_done && w_wr_oob;
      read_valid  <= w_rd_done;
      read_error  <= w_rd_done && w_rd_oob;
      if (w_rd_done)
        read_value <= w_rd_oob ? 32'h0 :
                      w_rd_size == ACC_BYTE ? {24'h0, r_mem[w_rd_idx]} :
                      {r_mem[{w_rd_idx[AW-1:2], 2'd3}], r_mem[{w_rd_idx[AW-1:2], 2'd2}],
                       r_mem[{w_rd_idx[AW-1:2], 2'd1}], r_mem[w_rd_idx]};
    end
  end
endmodule

// File: tb/tb_lsu_data_memory.sv
// tb_lsu_data_memory: directed checks of latency, data layout, range errors, reset and back-to-back timing.
module tb_lsu_data_memory;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        write_enable = 1'b0, store_byte = 1'b0, read_enable = 1'b0, load_byte = 1'b0;
  logic [31:0] write_address = '0, write_value = '0, read_address = '0;
  logic [31:0] read_value, read_value3;
  logic        write_valid, read_valid, read_error, write_error;
  logic        write_valid3, read_valid3, read_error3, write_error3;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  lsu_data_memory dut (
    .clk(clk), .reset_n(reset_n), .write_enable(write_enable), .write_address(write_address),
    .write_value(write_value), .store_byte(store_byte), .read_enable(read_enable),
    .read_address(read_address), .load_byte(load_byte), .read_value(read_value),
    .write_valid(write_valid), .read_valid(read_valid), .read_error(read_error), .write_error(write_error)
  );

  lsu_data_memory #(.WRITE_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .write_enable(write_enable), .write_address(write_address),
    .write_value(write_value), .store_byte(store_byte), .read_enable(read_enable),
    .read_address(read_address), .load_byte(load_byte), .read_value(read_value3),
    .write_valid(write_valid3), .read_valid(read_valid3), .read_error(read_error3), .write_error(write_error3)
  );

  task automatic do_write(input logic [31:0] a, input logic [31:0] v, input logic b,
                          output int lat, output logic err);
    write_address = a; write_value = v; store_byte = b; write_enable = 1'b1;
    @(posedge clk); #1;
    write_enable = 1'b0;
    lat = -1; err = 1'bx;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (write_valid) begin lat = n; err = write_error; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, input logic b,
                         output int lat, output logic [31:0] v, output logic err);
    read_address = a; load_byte = b; read_enable = 1'b1;
    @(posedge clk); #1;
    read_enable = 1'b0;
    lat = -1; err = 1'bx; v = 'x;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (read_valid) begin lat = n; err = read_error; v = read_value; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({read_value, read_valid, write_valid, read_error, write_error} !== 36'h0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", {read_value, read_valid, write_valid, read_error, write_error});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word;
    int lat; logic err; logic [31:0] v;
    do_write(32'h10, 32'hDEADBEEF, 1'b0, lat, err);
    checks++; if (lat !== 10) begin errors++; $display("FAIL word_write_latency: got %0d required 10", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL word_write_error: got %b required 0", err); end
    do_read(32'h10, 1'b0, lat, v, err);
    checks++; if (lat !== 10) begin errors++; $display("FAIL word_read_latency: got %0d required 10", lat); end
    checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL word_read_value: got %h required deadbeef", v); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL word_read_error: got %b required 0", err); end
    @(posedge clk); #1;
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL read_pulse_width: got %b required 0", read_valid); end
    checks++; if (read_value !== 32'hDEADBEEF) begin errors++; $display("FAIL read_value_hold: got %h required deadbeef", read_value); end
  endtask

  task automatic test_byte;
    int lat; logic err; logic [31:0] v;
    do_write(32'h13, 32'hFFFFFFAB, 1'b1, lat, err);
    do_read(32'h13, 1'b1, lat, v, err);
    checks++; if (v !== 32'h000000AB) begin errors++; $display("FAIL byte_load: got %h required 000000ab", v); end
    do_read(32'h10, 1'b0, lat, v, err);
    checks++; if (v !== 32'hABADBEEF) begin errors++; $display("FAIL byte_merge_word: got %h required abadbeef", v); end
    do_read(32'h11, 1'b1, lat, v, err);
    checks++; if (v !== 32'h000000BE) begin errors++; $display("FAIL byte_load_lane1: got %h required 000000be", v); end
  endtask

  task automatic test_misaligned;
    int lat; logic err; logic [31:0] v;
    do_write(32'h22, 32'h11223344, 1'b0, lat, err);
    do_read(32'h20, 1'b0, lat, v, err);
    checks++; if (v !== 32'h11223344) begin errors++; $display("FAIL misaligned_word: got %h required 11223344", v); end
    do_read(32'h23, 1'b1, lat, v, err);
    checks++; if (v !== 32'h00000011) begin errors++; $display("FAIL misaligned_byte3: got %h required 00000011", v); end
  endtask

  task automatic test_out_of_range;
    int lat; logic err; logic [31:0] v;
    do_read(32'h2000, 1'b0, lat, v, err);
    checks++; if (lat !== 10) begin errors++; $display("FAIL oob_read_latency: got %0d required 10", lat); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oob_read_error: got %b required 1", err); end
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL oob_read_value: got %h required 0", v); end
    do_write(32'h2000, 32'hCAFEF00D, 1'b0, lat, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oob_write_error: got %b required 1", err); end
    do_read(32'h0, 1'b0, lat, v, err);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL oob_no_alias: got %h required 0", v); end
    do_read(32'h1FFF, 1'b1, lat, v, err);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL last_byte_in_range: got %b required 0", err); end
  endtask

  task automatic test_reset_mid_read;
    int lat; logic err; logic [31:0] v; int seen;
    do_read(32'h10, 1'b0, lat, v, err);
    read_address = 32'h20; load_byte = 1'b0; read_enable = 1'b1;
    @(posedge clk); #1;
    read_enable = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (read_value !== 32'h0) begin errors++; $display("FAIL reset_async_value: got %h required 0", read_value); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (read_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_drops_read: got %0d pulses required 0", seen); end
    do_read(32'h10, 1'b0, lat, v, err);
    checks++; if (v !== 32'hABADBEEF) begin errors++; $display("FAIL reset_keeps_array: got %h required abadbeef", v); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL post_reset_latency: got %0d required 10", lat); end
  endtask

  task automatic test_back_to_back;
    int last, npulse;
    logic prev;
    last = -1; npulse = 0; prev = 1'b0;
    write_address = 32'h40; write_value = 32'h5; store_byte = 1'b0; write_enable = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      if (write_valid3) begin
        if (prev) begin
          checks++; errors++; $display("FAIL b2b_pulse_width: got 2+ cycles required 1");
        end
        if (last >= 0) begin
          checks++;
          if (c - last !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d required 4", c - last); end
        end
        last = c; npulse++;
      end
      prev = write_valid3;
    end
    write_enable = 1'b0;
    checks++; if (npulse < 5) begin errors++; $display("FAIL b2b_pulse_count: got %0d required >=5", npulse); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_misaligned;
    test_out_of_range;
    test_reset_mid_read;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
